// File: rtl/mmio_read_ctrl.sv
// MEM-stage load sequencer: DMEM loads pass through, peripheral loads use a req/ack handshake and stall the pipeline.
// Optional abort-on-timeout of a peripheral read is built when MMIO_READ_TIMEOUT_EN is defined.
module mmio_read_ctrl #(
    parameter int PER_BASE_BIT   = 11,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_rd_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        per_req,
    output logic [2:0]  per_sel,
    input  logic        per_ack,
    input  logic [31:0] per_rdata,
    output logic        per_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          NUM_PER = 7;
    localparam logic [11:0] PER_ADDR [0:NUM_PER-1] = '{
        12'h808, 12'h80C, 12'h814, 12'h820, 12'h824, 12'h828, 12'h834
    };

    state_t        state_reg;
    state_t        state_next;
    logic [NUM_PER-1:0] addr_match;
    logic          dec_valid;
    logic [2:0]    dec_sel;
    logic          per_hit;
    logic          ack_take;
    logic          timeout_hit;
    logic          per_req_reg;
    logic [2:0]    per_sel_reg;
    logic [31:0]   rdata_q_reg;
    logic          addr_unused;

    // Only the low 12 bits and the window bit take part in decode.
    assign addr_unused = ^cpu_addr;

    for (genvar gi = 0; gi < NUM_PER; gi++) begin : g_dec
        assign addr_match[gi] = (cpu_addr[11:0] == PER_ADDR[gi]);
    end

    always_comb begin
        dec_sel = 3'd0;
        for (int i = 0; i < NUM_PER; i++) begin
            if (addr_match[i]) dec_sel = 3'(i);
        end
    end

    assign dec_valid = cpu_addr[PER_BASE_BIT] & (|addr_match);
    assign per_hit   = cpu_rd_en & dec_valid;
    assign ack_take  = (state_reg == WAIT) & per_ack;

`ifdef MMIO_READ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] tmo_cnt_reg;
    logic [CNT_W-1:0] tmo_cnt_inc;
    logic             per_err_reg;

    assign tmo_cnt_inc = tmo_cnt_reg + CNT_W'(1);
    // Ack has priority over a timeout landing in the same cycle.
    assign timeout_hit = (state_reg == WAIT) & ~per_ack & (tmo_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg <= '0;
            per_err_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && per_hit) begin
                tmo_cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                tmo_cnt_reg <= tmo_cnt_inc;
            end
            if (timeout_hit) begin
                per_err_reg <= 1'b1;
            end
        end
    end

    assign per_err = per_err_reg;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign per_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (per_hit) state_next = WAIT;
            WAIT:    if (ack_take || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        rdata = dmem_rdata;
        case (state_reg)
            IDLE:    stall = per_hit;
            WAIT:    stall = 1'b1;
            DONE:    rdata = rdata_q_reg;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_req_reg <= 1'b0;
            per_sel_reg <= 3'd0;
            rdata_q_reg <= 32'd0;
        end else begin
            if (state_reg == IDLE && per_hit) begin
                per_req_reg <= 1'b1;
                per_sel_reg <= dec_sel;
            end else if (ack_take) begin
                per_req_reg <= 1'b0;
                rdata_q_reg <= per_rdata;
            end else if (timeout_hit) begin
                per_req_reg <= 1'b0;
                rdata_q_reg <= 32'hDEAD_BEEF;
            end
        end
    end

    assign per_req = per_req_reg;
    assign per_sel = per_sel_reg;

endmodule
